// File: rtl/posit_mult_arbiter.sv
// Two-requester round-robin front end for a shared, fixed-latency posit multiplier.
// Results are steered back to the issuing requester by a tag pipe that tracks the multiplier latency.
module posit_mult_arbiter #(
    parameter int unsigned N   = 32,
    parameter int unsigned LAT = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         mul_start,
    output logic [N-1:0] mul_in1,
    output logic [N-1:0] mul_in2,
    input  logic [N-1:0] mul_out,
    input  logic         mul_inf,
    input  logic         mul_zero,
    input  logic         mul_done,
    output logic         rsp0_valid,
    output logic [N-1:0] rsp0_data,
    output logic         rsp0_inf,
    output logic         rsp0_zero,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp1_data,
    output logic         rsp1_inf,
    output logic         rsp1_zero,
    output logic [2:0]   inflight,
    output logic         idle,
    output logic         seq_err
);

    localparam int unsigned WARM_W    = $clog2(LAT + 2);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(LAT + 1);
    localparam logic [2:0] INFL_MAX  = 3'(LAT + 1);

    logic [WARM_W-1:0] warm_cnt;
    logic              warm;
    logic              rr_pri;
    logic              issue_id;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic [LAT-1:0]    tag_v;
    logic [LAT-1:0]    tag_id;
    logic              done_v;
    logic              done_id;

    assign warm    = (warm_cnt != '0);
    assign done_v  = tag_v[LAT-1];
    assign done_id = tag_id[LAT-1];
    assign gnt_any = gnt0 | gnt1;

    // rr_pri names the requester that wins when both are valid
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!warm) begin
            if (req0_valid && (!req1_valid || !rr_pri)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_start <= 1'b0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            issue_id  <= 1'b0;
            rr_pri    <= 1'b0;
        end else begin
            mul_start <= gnt_any;
            if (gnt0) begin
                mul_in1 <= req0_a;
                mul_in2 <= req0_b;
            end else if (gnt1) begin
                mul_in1 <= req1_a;
                mul_in2 <= req1_b;
            end
            if (gnt_any) begin
                issue_id <= gnt1;
                rr_pri   <= gnt0;
            end
        end
    end

    // Tag pipe: the entry loaded at mul_start leaves the last stage with the matching mul_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            tag_v[0]  <= mul_start;
            tag_id[0] <= issue_id;
        end
    end

    assign rsp0_valid = done_v & ~done_id;
    assign rsp1_valid = done_v & done_id;
    assign rsp0_data  = mul_out;
    assign rsp0_inf   = mul_inf;
    assign rsp0_zero  = mul_zero;
    assign rsp1_data  = mul_out;
    assign rsp1_inf   = mul_inf;
    assign rsp1_zero  = mul_zero;

    // Occupancy counted from accept to response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (gnt_any && !done_v) begin
            if (inflight != INFL_MAX) begin
                inflight <= inflight + 3'd1;
            end
        end else if (done_v && !gnt_any) begin
            if (inflight != '0) begin
                inflight <= inflight - 3'd1;
            end
        end
    end

    assign idle = (inflight == '0) && !req0_valid && !req1_valid;

    // Unreset multiplier pipe may emit stale done pulses until it has fully flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_cnt <= WARM_INIT;
            seq_err  <= 1'b0;
        end else begin
            if (warm) begin
                warm_cnt <= warm_cnt - WARM_W'(1);
            end else if (mul_done != done_v) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// Bench for posit_mult_arbiter: a stand-in unreset multiplier pipe plus a per-requester
// response scoreboard that checks data, flags and accept-to-response latency.
module tb_posit_mult_arbiter;

    localparam int unsigned N   = 32;
    localparam int unsigned LAT = 5;
    localparam logic [N-1:0] NAR = 32'h8000_0000;
    localparam logic [N-1:0] ONE = 32'h4000_0000;

    typedef struct packed {
        logic        inf;
        logic        zero;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         mul_start;
    logic [N-1:0] mul_in1, mul_in2, mul_out;
    logic         mul_inf, mul_zero, mul_done;
    logic         rsp0_valid, rsp0_inf, rsp0_zero;
    logic         rsp1_valid, rsp1_inf, rsp1_zero;
    logic [N-1:0] rsp0_data, rsp1_data;
    logic [2:0]   inflight;
    logic         idle, seq_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    logic        inject = 1'b0;
    exp_t        q0[$];
    exp_t        q1[$];

    posit_mult_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_start(mul_start), .mul_in1(mul_in1), .mul_in2(mul_in2),
        .mul_out(mul_out), .mul_inf(mul_inf), .mul_zero(mul_zero), .mul_done(mul_done),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_inf(rsp0_inf), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_inf(rsp1_inf), .rsp1_zero(rsp1_zero),
        .inflight(inflight), .idle(idle), .seq_err(seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in multiplier: {inf, zero, data}; special-value handling follows posit rules
    function automatic logic [N+1:0] fake_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic inf, zero;
        logic [N-1:0] d;
        inf  = (a == NAR) || (b == NAR);
        zero = !inf && ((a == '0) || (b == '0));
        d    = inf ? NAR : (zero ? '0 : (a ^ {b[15:0], b[31:16]} ^ 32'h5a5a_0001));
        return {inf, zero, d};
    endfunction

    // Unreset multiplier pipe, deliberately starting with garbage in flight
    logic [LAT-1:0] mp_v = 5'b10110;
    logic [N+1:0]   mp_d [LAT];
    always @(posedge clk) begin
        mp_v    <= {mp_v[LAT-2:0], mul_start};
        mp_d[0] <= fake_mul(mul_in1, mul_in2);
        for (int i = 1; i < LAT; i++) mp_d[i] <= mp_d[i-1];
    end
    assign mul_done = mp_v[LAT-1] | inject;
    assign {mul_inf, mul_zero, mul_out} = mp_d[LAT-1];

    // Scoreboard: push on accept, pop and compare when a response appears
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (!rst) begin
            if (rsp0_valid) begin
                vectors++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp0_unexpected at cyc=%0d data=%h expected no response", cyc, rsp0_data);
                end else begin
                    e = q0.pop_front();
                    g = '{rsp0_inf, rsp0_zero, rsp0_data, cyc};
                    if (g !== e) begin
                        miscompares++;
                        $display("FAIL rsp0 got inf=%b zero=%b data=%h cyc=%0d expected inf=%b zero=%b data=%h cyc=%0d",
                                 g.inf, g.zero, g.data, g.due, e.inf, e.zero, e.data, e.due);
                    end
                end
            end
            if (rsp1_valid) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp1_unexpected at cyc=%0d data=%h expected no response", cyc, rsp1_data);
                end else begin
                    e = q1.pop_front();
                    g = '{rsp1_inf, rsp1_zero, rsp1_data, cyc};
                    if (g !== e) begin
                        miscompares++;
                        $display("FAIL rsp1 got inf=%b zero=%b data=%h cyc=%0d expected inf=%b zero=%b data=%h cyc=%0d",
                                 g.inf, g.zero, g.data, g.due, e.inf, e.zero, e.data, e.due);
                    end
                end
            end
            if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) || (req1_ready && !req1_valid)) begin
                miscompares++;
                $display("FAIL grant_legal at cyc=%0d got ready0=%b ready1=%b valid0=%b valid1=%b expected one grant to a valid requester",
                         cyc, req0_ready, req1_ready, req0_valid, req1_valid);
            end
            if (req0_ready) begin
                {e.inf, e.zero, e.data} = fake_mul(req0_a, req0_b);
                e.due = cyc + LAT + 1;
                q0.push_back(e);
            end
            if (req1_ready) begin
                {e.inf, e.zero, e.data} = fake_mul(req1_a, req1_b);
                e.due = cyc + LAT + 1;
                q1.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        req1_valid = 1'b1;
        req1_a = 32'h1234_5678; req1_b = 32'h0bad_cafe;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mul_start, idle, seq_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got rdy=%b%b rsp=%b%b start=%b idle=%b err=%b expected all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, mul_start, idle, seq_err);
        end
        vectors++;
        if ({inflight, mul_in1, mul_in2} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got inflight=%0d in1=%h in2=%h expected 0 0 0", inflight, mul_in1, mul_in2);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i <= int'(LAT) + 1; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            vectors++;
            if (req1_ready !== (i == int'(LAT) + 1)) begin
                miscompares++;
                $display("FAIL warmup_ready step %0d got %b expected %b", i, req1_ready, (i == int'(LAT) + 1));
            end
        end
        tick();
        req1_valid = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if ({inflight, idle} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_drain got inflight=%0d idle=%b expected 0 1", inflight, idle);
        end
    endtask

    task automatic test_contention();
        int unsigned peak = 0;
        logic [3:0]  order = '0;
        int          nrsp = 0, first = -1, last = -1;
        for (int i = 0; i < 14; i++) begin
            tick();
            req0_valid = (i < 4);
            req1_valid = (i < 4);
            req0_a = 32'h4800_0000 + 32'(i); req0_b = 32'h3c00_0000 + 32'(i);
            req1_a = 32'h5000_0000 + 32'(i); req1_b = 32'h2000_0000 + 32'(i);
            @(negedge clk);
            if (i < 4) begin
                vectors++;
                if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL contention_grant step %0d got rdy0=%b rdy1=%b expected grant to %0d",
                             i, req0_ready, req1_ready, i % 2);
                end
            end
            if (32'(inflight) > peak) peak = 32'(inflight);
            if (rsp0_valid || rsp1_valid) begin
                order = {order[2:0], rsp1_valid};
                nrsp++;
                if (first < 0) first = i;
                last = i;
            end
        end
        vectors++;
        if (peak !== 4) begin
            miscompares++;
            $display("FAIL contention_peak got %0d expected 4", peak);
        end
        vectors++;
        if (order !== 4'b0101 || nrsp != 4 || last - first != 3) begin
            miscompares++;
            $display("FAIL contention_order got ids=%b count=%0d span=%0d expected 0101 4 3", order, nrsp, last - first);
        end
    endtask

    task automatic test_single();
        int unsigned t0, trsp = 0;
        int          n1 = 0;
        tick();
        req0_valid = 1'b1; req0_a = ONE; req0_b = ONE;
        @(negedge clk);
        t0 = cyc;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept got %b expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mul_start, mul_in1, mul_in2} !== {1'b1, ONE, ONE}) begin
            miscompares++;
            $display("FAIL single_issue got start=%b in1=%h in2=%h expected 1 %h %h", mul_start, mul_in1, mul_in2, ONE, ONE);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (i == 0) begin
                vectors++;
                if (mul_start !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_start_drop got %b expected 0", mul_start);
                end
            end
            if (rsp0_valid) trsp = cyc;
            if (rsp1_valid) n1++;
        end
        vectors++;
        if (trsp != t0 + LAT + 1 || n1 != 0) begin
            miscompares++;
            $display("FAIL single_latency got %0d cycles, rsp1 count %0d expected %0d cycles, 0", trsp - t0, n1, LAT + 1);
        end
    endtask

    task automatic test_stream();
        int n_start = 0, n_rsp = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            req1_valid = (i < 20);
            req1_a = $urandom; req1_b = $urandom;
            @(negedge clk);
            if (i < 20) begin
                vectors++;
                if (req1_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_ready step %0d got %b expected 1", i, req1_ready);
                end
            end
            if (i == 10) begin
                vectors++;
                if (inflight !== 3'(LAT + 1)) begin
                    miscompares++;
                    $display("FAIL stream_inflight got %0d expected %0d", inflight, LAT + 1);
                end
            end
            if (mul_start) n_start++;
            if (rsp1_valid) n_rsp++;
        end
        vectors++;
        if (n_start != 20 || n_rsp != 20) begin
            miscompares++;
            $display("FAIL stream_counts got start=%0d rsp=%0d expected 20 20", n_start, n_rsp);
        end
        vectors++;
        if ({inflight, idle, seq_err} !== 5'b00010) begin
            miscompares++;
            $display("FAIL stream_drain got inflight=%0d idle=%b err=%b expected 0 1 0", inflight, idle, seq_err);
        end
    endtask

    task automatic test_special();
        int n_inf = 0, n_zero = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            req0_valid = (i == 0); req0_a = NAR; req0_b = ONE;
            req1_valid = (i < 2);  req1_a = '0;  req1_b = 32'h3000_0000;
            @(negedge clk);
            if (rsp0_valid && rsp0_inf && !rsp0_zero) n_inf++;
            if (rsp1_valid && rsp1_zero && !rsp1_inf) n_zero++;
        end
        vectors++;
        if (n_inf != 1 || n_zero != 1) begin
            miscompares++;
            $display("FAIL special_flags got inf_rsp=%0d zero_rsp=%0d expected 1 1", n_inf, n_zero);
        end
    endtask

    task automatic test_reset_midflight();
        int n0 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_valid = (i < 3);
            req0_a = 32'h4400_0000 + 32'(i); req0_b = 32'h4200_0000;
            @(negedge clk);
        end
        tick();
        rst = 1'b1;
        q0.delete(); q1.delete();
        req0_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req0_ready, rsp0_valid, rsp1_valid, inflight} !== 6'b0) begin
            miscompares++;
            $display("FAIL midflight_rst got rdy=%b rsp=%b%b inflight=%0d expected 0 00 0",
                     req0_ready, rsp0_valid, rsp1_valid, inflight);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i <= int'(LAT) + 1; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            vectors++;
            if (req0_ready !== (i == int'(LAT) + 1)) begin
                miscompares++;
                $display("FAIL midflight_warmup step %0d got %b expected %b", i, req0_ready, (i == int'(LAT) + 1));
            end
            if (rsp0_valid) n0++;
        end
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp0_valid) n0++;
        end
        vectors++;
        if (n0 != 1 || seq_err !== 1'b0 || inflight !== 3'd0) begin
            miscompares++;
            $display("FAIL midflight_after got rsp0=%0d err=%b inflight=%0d expected 1 0 0", n0, seq_err, inflight);
        end
    endtask

    task automatic test_seq_err();
        tick();
        inject = 1'b1;
        @(negedge clk);
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_err_early got %b expected 0", seq_err);
        end
        tick();
        inject = 1'b0;
        @(negedge clk);
        vectors++;
        if (seq_err !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_err_set got %b expected 1", seq_err);
        end
        repeat (5) tick();
        @(negedge clk);
        vectors++;
        if (seq_err !== 1'b1) begin
            miscompares++;
            $display("FAIL seq_err_sticky got %b expected 1", seq_err);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (seq_err !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_err_clear got %b expected 0", seq_err);
        end
        tick();
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_stream();
        test_special();
        test_reset_midflight();
        test_seq_err();
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty got q0=%0d q1=%0d pending expected 0 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
